// File: rtl/fetch_stall_ctrl_if.sv
// Stall/flush, branch-redirect, instruction-memory and IF/ID signals of the fetch stall controller.
// master: hazard unit, branch unit and imem side. slave: fetch_stall_ctrl.
interface fetch_stall_ctrl_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
);
  logic               ctrl_flush;
  logic               PCwrite;
  logic               Id_write;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic               id_ex_valid;
  logic               stall_timeout;

  modport master (
    output ctrl_flush, PCwrite, Id_write, br_taken, br_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, id_ex_valid, stall_timeout
  );

  modport slave (
    input  ctrl_flush, PCwrite, Id_write, br_taken, br_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, id_ex_valid, stall_timeout
  );
endinterface

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall controller: owns PC/imem fetch address, IF/ID register and ID/EX valid bit.
// Applies hazard-unit stalls, bubbles and branch redirects around a 1-cycle synchronous imem.
// Optional stall watchdog enabled by defining FETCH_STALL_WATCHDOG_EN.
module fetch_stall_ctrl #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
`ifdef FETCH_STALL_WATCHDOG_EN
  ,
  parameter int unsigned MAX_STALL = 7
`endif
) (
  input logic             clk,
  input logic             rst,
  fetch_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic [PC_W-1:0]    rdata_pc_q, rdata_pc_d;
  logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
  logic               if_id_valid_q, if_id_valid_d;
  logic               id_ex_valid_q, id_ex_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic               hold_vld_q, hold_vld_d;
  logic [INSTR_W-1:0] fetch_instr_c;

  // While the fetch address is held the imem re-reads it, so the first word returned
  // is parked here to stay paired with rdata_pc.
  assign fetch_instr_c = hold_vld_q ? hold_instr_q : bus.imem_rdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    imem_addr_d   = imem_addr_q;
    rdata_pc_d    = rdata_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_vld_d    = hold_vld_q;
    id_ex_valid_d = if_id_valid_q & ~bus.ctrl_flush & ~bus.br_taken;

    case (state_q)
      ST_REDIRECT: begin
        // Returned word is from the wrong path; hazard controls refer to a dead instruction.
        rdata_pc_d    = imem_addr_q;
        if_id_instr_d = '0;
        if_id_pc_d    = rdata_pc_q;
        if_id_valid_d = 1'b0;
        hold_vld_d    = 1'b0;
        if (bus.br_taken) begin
          imem_addr_d = bus.br_target;
          state_d     = ST_REDIRECT;
        end else begin
          imem_addr_d = imem_addr_q + PC_W'(1);
          state_d     = ST_RUN;
        end
      end
      default: begin
        if (bus.br_taken) begin
          imem_addr_d   = bus.br_target;
          rdata_pc_d    = imem_addr_q;
          if_id_instr_d = '0;
          if_id_valid_d = 1'b0;
          hold_vld_d    = 1'b0;
          state_d       = ST_REDIRECT;
        end else begin
          if (bus.PCwrite) begin
            imem_addr_d = imem_addr_q + PC_W'(1);
            rdata_pc_d  = imem_addr_q;
            hold_vld_d  = 1'b0;
            state_d     = ST_RUN;
          end else begin
            state_d = ST_STALL;
            if (!hold_vld_q) begin
              hold_instr_d = bus.imem_rdata;
              hold_vld_d   = 1'b1;
            end
          end
          if (bus.Id_write) begin
            if_id_instr_d = fetch_instr_c;
            if_id_pc_d    = rdata_pc_q;
            if_id_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Fetch, IF/ID and ID/EX registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr_q   <= PC_W'(RESET_PC);
      rdata_pc_q    <= PC_W'(RESET_PC);
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      id_ex_valid_q <= 1'b0;
      hold_instr_q  <= '0;
      hold_vld_q    <= 1'b0;
    end else begin
      imem_addr_q   <= imem_addr_d;
      rdata_pc_q    <= rdata_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_valid_q <= id_ex_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_vld_q    <= hold_vld_d;
    end
  end

`ifdef FETCH_STALL_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_timeout_q, stall_timeout_d;

  // Count consecutive fetch-hold edges outside a redirect; sticky flag on saturation.
  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    if (bus.br_taken || bus.PCwrite || (state_q == ST_REDIRECT)) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CNT_W'(MAX_STALL)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (stall_cnt_d == CNT_W'(MAX_STALL)) stall_timeout_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign bus.stall_timeout = stall_timeout_q;
`else
  assign bus.stall_timeout = 1'b0;
`endif

  assign bus.imem_addr   = imem_addr_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.id_ex_valid = id_ex_valid_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl with a synchronous imem returning 16'h1000 + addr.
// Build with FETCH_STALL_WATCHDOG_EN defined to exercise the watchdog.
module tb_fetch_stall_ctrl;

`ifdef FETCH_STALL_WATCHDOG_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch_stall_ctrl_if #(.PC_W(16), .INSTR_W(16)) bus ();

  fetch_stall_ctrl #(.PC_W(16), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous instruction memory model.
  always @(posedge clk) bus.imem_rdata <= 16'h1000 + bus.imem_addr;

  task automatic drive(input logic f, input logic p, input logic i, input logic b,
                       input logic [15:0] t);
    bus.ctrl_flush = f;
    bus.PCwrite    = p;
    bus.Id_write   = i;
    bus.br_taken   = b;
    bus.br_target  = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.imem_addr !== 16'h0000 || bus.if_id_instr !== 16'h0000 || bus.if_id_pc !== 16'h0000 ||
        bus.if_id_valid !== 1'b0 || bus.id_ex_valid !== 1'b0 || bus.stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%h instr=%h pc=%h v=%b ex=%b to=%b expected 0000 0000 0000 0 0 0",
               bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.id_ex_valid,
               bus.stall_timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      n_chk++;
      if (bus.imem_addr !== 16'(k)) begin
        n_fail++;
        $display("FAIL seq_addr edge %0d: got %h expected %h", k, bus.imem_addr, 16'(k));
      end
      if (k >= 2) begin
        n_chk++;
        if (bus.if_id_instr !== 16'(16'h1000 + k - 2) || bus.if_id_pc !== 16'(k - 2)) begin
          n_fail++;
          $display("FAIL seq_ifid edge %0d: got %h/%h expected %h/%h", k, bus.if_id_instr,
                   bus.if_id_pc, 16'(16'h1000 + k - 2), 16'(k - 2));
        end
      end
      if (k >= 3) begin
        n_chk++;
        if (bus.if_id_valid !== 1'b1 || bus.id_ex_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL seq_valid edge %0d: got %b/%b expected 1/1", k, bus.if_id_valid,
                   bus.id_ex_valid);
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic [15:0] exp_addr [3] = '{16'h0005, 16'h0006, 16'h0007};
    logic [15:0] exp_ins  [3] = '{16'h1003, 16'h1004, 16'h1005};
    logic        exp_ex   [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    repeat (5) step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      n_chk++;
      if (bus.imem_addr !== exp_addr[k] || bus.if_id_instr !== exp_ins[k] ||
          bus.if_id_pc !== exp_ins[k] - 16'h1000 || bus.id_ex_valid !== exp_ex[k]) begin
        n_fail++;
        $display("FAIL load_use %0d: got addr=%h instr=%h pc=%h ex=%b expected %h %h %h %b", k,
                 bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.id_ex_valid, exp_addr[k],
                 exp_ins[k], exp_ins[k] - 16'h1000, exp_ex[k]);
      end
    end
  endtask

  task automatic test_stall_id_write();
    logic [15:0] exp_addr [4] = '{16'h0005, 16'h0005, 16'h0006, 16'h0007};
    logic [15:0] exp_ins  [4] = '{16'h1004, 16'h1004, 16'h1004, 16'h1005};
    do_reset();
    repeat (5) step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      n_chk++;
      if (bus.imem_addr !== exp_addr[k] || bus.if_id_instr !== exp_ins[k] ||
          bus.if_id_pc !== exp_ins[k] - 16'h1000 || bus.if_id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_idw %0d: got addr=%h instr=%h pc=%h v=%b expected %h %h %h 1", k,
                 bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, exp_addr[k],
                 exp_ins[k], exp_ins[k] - 16'h1000);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp_addr [4] = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
    logic        exp_v    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        exp_ex   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    repeat (9) step();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040);
    for (int k = 0; k < 4; k++) begin
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
      n_chk++;
      if (bus.imem_addr !== exp_addr[k] || bus.if_id_valid !== exp_v[k] ||
          bus.id_ex_valid !== exp_ex[k]) begin
        n_fail++;
        $display("FAIL branch %0d: got addr=%h v=%b ex=%b expected %h %b %b", k, bus.imem_addr,
                 bus.if_id_valid, bus.id_ex_valid, exp_addr[k], exp_v[k], exp_ex[k]);
      end
      if (k >= 2) begin
        n_chk++;
        if (bus.if_id_instr !== 16'h1040 + 16'(k - 2) || bus.if_id_pc !== 16'h0040 + 16'(k - 2)) begin
          n_fail++;
          $display("FAIL branch_ifid %0d: got %h/%h expected %h/%h", k, bus.if_id_instr,
                   bus.if_id_pc, 16'h1040 + 16'(k - 2), 16'h0040 + 16'(k - 2));
        end
      end
    end
  endtask

  task automatic test_branch_vs_stall();
    logic [15:0] exp_addr [3] = '{16'h0020, 16'h0021, 16'h0021};
    do_reset();
    repeat (3) step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0020);
    for (int k = 0; k < 3; k++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      n_chk++;
      if (bus.imem_addr !== exp_addr[k] || bus.if_id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL br_vs_stall %0d: got addr=%h v=%b expected %h 0", k, bus.imem_addr,
                 bus.if_id_valid, exp_addr[k]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (2) step();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    n_chk++;
    if (bus.imem_addr !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_pre: got %h expected ffff", bus.imem_addr);
    end
    step();
    n_chk++;
    if (bus.imem_addr !== 16'h0000 || bus.if_id_instr !== 16'h0FFE || bus.if_id_pc !== 16'hFFFE ||
        bus.if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: got addr=%h instr=%h pc=%h v=%b expected 0000 0ffe fffe 1",
               bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.imem_addr !== 16'h0000 || bus.if_id_instr !== 16'h0000 || bus.if_id_pc !== 16'h0000 ||
        bus.if_id_valid !== 1'b0 || bus.id_ex_valid !== 1'b0 || bus.stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got addr=%h instr=%h pc=%h v=%b ex=%b to=%b expected 0000 0000 0000 0 0 0",
               bus.imem_addr, bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.id_ex_valid,
               bus.stall_timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (6) step();
    n_chk++;
    if (bus.stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_6_stalls: got %b expected 0", bus.stall_timeout);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    n_chk++;
    if (bus.stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear: got %b expected 0", bus.stall_timeout);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (7) step();
    n_chk++;
    if (bus.stall_timeout !== EXP_TO) begin
      n_fail++;
      $display("FAIL wd_7_stalls: got %b expected %b", bus.stall_timeout, EXP_TO);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (2) step();
    n_chk++;
    if (bus.stall_timeout !== EXP_TO) begin
      n_fail++;
      $display("FAIL wd_sticky: got %b expected %b", bus.stall_timeout, EXP_TO);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load_use();
    test_stall_id_write();
    test_branch();
    test_branch_vs_stall();
    test_wrap();
    test_async_reset();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Consumer end of the stall/flush interface driven by the pipeline hazard unit (ctrl_flush, PCwrite, Id_write).
- Owns the PC and the instruction-memory fetch address, the IF/ID pipeline register and the ID/EX valid bit.
- Applies stalls, inserts bubbles and performs branch redirects with a synchronous (1-cycle latency) instruction memory.
- Sits between instruction memory and the decode stage of the 8-register RISC pipeline.

Parameters:
- PC_W, 16, width of PC and instruction-memory word address.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, first fetch address after reset.
- MAX_STALL, 7, consecutive stall cycles before watchdog flag; only used with the watchdog macro.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_flush  in  1  from hazard unit: kill instruction leaving ID (bubble into ID/EX).
- PCwrite  in  1  from hazard unit: 1 = advance fetch, 0 = hold fetch.
- Id_write  in  1  from hazard unit: 1 = load IF/ID, 0 = hold IF/ID.
- br_taken  in  1  branch resolved taken this cycle.
- br_target  in  PC_W  redirect address, valid with br_taken.
- imem_addr  out  PC_W  registered fetch address.
- imem_rdata  in  INSTR_W  instruction for previous cycle's imem_addr.
- if_id_instr  out  INSTR_W  IF/ID instruction.
- if_id_pc  out  PC_W  address of if_id_instr.
- if_id_valid  out  1  IF/ID holds a real instruction.
- id_ex_valid  out  1  ID/EX control valid; 0 = bubble.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values, applied asynchronously:
  - imem_addr=RESET_PC; internal rdata_pc=RESET_PC.
  - if_id_instr=0 (NOP), if_id_pc=0, if_id_valid=0, id_ex_valid=0.
  - stall_timeout=0, stall_cnt=0, state=RUN.
- rdata_pc tracks the address of imem_rdata:
  - Loads imem_addr on each edge where imem_addr advances or redirects.
  - Holds otherwise.
- State RUN, priority br_taken > PCwrite:
  - br_taken=1: imem_addr<=br_target; if_id_valid<=0; if_id_instr<=0; state<=REDIRECT.
  - else PCwrite=1: imem_addr<=imem_addr+1, wrapping modulo 2^PC_W.
  - else PCwrite=0: imem_addr held; state<=STALL.
  - Id_write=1 and no br_taken: if_id_instr<=imem_rdata, if_id_pc<=rdata_pc, if_id_valid<=1.
  - Id_write=0: IF/ID held.
- State STALL:
  - Same update rules as RUN.
  - Returns to RUN on the first edge with PCwrite=1.
  - br_taken still redirects and overrides the stall.
- State REDIRECT, exactly one cycle:
  - imem_rdata belongs to the wrong path and is discarded.
  - imem_addr<=imem_addr+1; IF/ID loaded with if_id_valid<=0.
  - ctrl_flush, PCwrite and Id_write are ignored, since the hazard unit is comparing a dead instruction.
  - Next state is RUN, or REDIRECT again if br_taken=1.
- id_ex_valid<=if_id_valid & ~ctrl_flush & ~br_taken on every edge, in every state.
- Latency: instruction at address A reaches if_id_instr 2 edges after imem_addr=A when no stall occurs.
- PCwrite=0 with Id_write=1 is tolerated: IF/ID reloads the same held fetch (same instr, same pc).

Optional Feature:
- Macro: FETCH_STALL_WATCHDOG_EN.
- Defined:
  - stall_cnt counts consecutive edges with PCwrite=0 outside REDIRECT, saturating at MAX_STALL.
  - stall_cnt clears on PCwrite=1 or br_taken.
  - stall_timeout sets when stall_cnt reaches MAX_STALL and stays set until rst.
- Undefined:
  - No counter logic.
  - stall_timeout tied to 0.

Test Plan:
- Reset release, RESET_PC=0, imem returns 16'h1000+addr, no stalls -> imem_addr 0,1,2,...; if_id_instr 16'h1000 with if_id_pc 0 on the 2nd edge, then 16'h1001/1 on the 3rd edge; if_id_valid=1 and id_ex_valid=1 from the 3rd edge.
- Load-use stall: ctrl_flush=1, PCwrite=0, Id_write=0 for 1 cycle with imem_addr=5 -> imem_addr stays 5 one extra edge; IF/ID unchanged; id_ex_valid=0 exactly one cycle; then sequence resumes 6,7.
- Branch: br_taken=1, br_target=16'h0040 with imem_addr=9 -> imem_addr=16'h0040 next edge; if_id_valid=0 for 2 edges; instruction from 16'h0040 appears with if_id_valid=1 on the 3rd edge.
- Simultaneous br_taken=1 and PCwrite=0 -> redirect wins: imem_addr=br_target, state REDIRECT, stall ignored.
- Wrap: imem_addr=16'hFFFF, PCwrite=1 -> next imem_addr=16'h0000; async rst mid-stall -> all outputs return to reset values before the next clock edge.
- FETCH_STALL_WATCHDOG_EN, MAX_STALL=7: PCwrite=0 for 7 edges -> stall_timeout=1 and stays 1 after PCwrite returns to 1. PCwrite=0 for 6 edges -> stall_timeout stays 0.
